// File: rtl/uart_packet_rx_if.sv
`timescale 1ns/1ps
// Regfile-side bus of the serial command receiver: strobes, address/data and status.
// The receiver drives it through the master modport; the regfile consumes it through slave.
interface uart_packet_rx_if;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   logic              write;
   logic              read;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] write_data;
   logic [ADDR_W-1:0] read_addr;
   logic              frame_err;
   logic              parity_err;
   logic              busy;

   modport master (
      output write, read, write_addr, write_data, read_addr,
      output frame_err, parity_err, busy
   );

   modport slave (
      input write, read, write_addr, write_data, read_addr,
      input frame_err, parity_err, busy
   );
endinterface

// File: rtl/uart_packet_rx.sv
`timescale 1ns/1ps
// Serial command receiver: 18-bit packets on posi become one-cycle regfile write/read strobes.
// Optional macro PARITY_CHECK_EN drops packets failing even parity and pulses parity_err.
module uart_packet_rx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             posi,
   uart_packet_rx_if.master rx_if
);
   localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = 5;
   localparam int unsigned BODY_W = 17;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
   localparam logic [BIT_W-1:0] PAR_BIT   = BIT_W'(BODY_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e                  state_q;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic [CNT_W-1:0]        clk_cnt_q;
   logic [BIT_W-1:0]        bit_cnt_q;
   logic [BODY_W-1:0]       body_q;
   logic                    write_q;
   logic                    read_q;
   logic [ADDR_W-1:0]       write_addr_q;
   logic [DATA_W-1:0]       write_data_q;
   logic [ADDR_W-1:0]       read_addr_q;
   logic                    frame_err_q;
   logic                    busy_q;
   logic                    rx;
   logic                    parity_ok;
`ifdef PARITY_CHECK_EN
   logic                    parity_bad_q;
   logic                    parity_err_q;
`endif

   assign rx = sync_q[SYNC_STAGES-1];

`ifdef PARITY_CHECK_EN
   assign parity_ok = ~parity_bad_q;
`else
   assign parity_ok = 1'b1;
`endif

   // Body bits land LSB first: body_q[0]=wrb, [8:1]=data, [16:9]=addr; the parity bit is not stored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         sync_q       <= '1;
         clk_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         body_q       <= '0;
         write_q      <= 1'b0;
         read_q       <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         read_addr_q  <= '0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_bad_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], posi};
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (!rx) begin
                  clk_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= S_START;
               end
            end

            S_START: begin
               if (clk_cnt_q == HALF_LAST) begin
                  clk_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  if (rx) begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_DATA;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end

            S_DATA: begin
               if (clk_cnt_q == FULL_LAST) begin
                  clk_cnt_q <= '0;
                  bit_cnt_q <= bit_cnt_q + BIT_ONE;
                  if (bit_cnt_q == PAR_BIT) begin
`ifdef PARITY_CHECK_EN
                     parity_bad_q <= rx ^ (^body_q);
`endif
                     state_q <= S_STOP;
                  end else begin
                     body_q <= {rx, body_q[BODY_W-1:1]};
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end

            S_STOP: begin
               if (clk_cnt_q == FULL_LAST) begin
                  clk_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
                  if (!rx) begin
                     frame_err_q <= 1'b1;
                  end else if (!parity_ok) begin
`ifdef PARITY_CHECK_EN
                     parity_err_q <= 1'b1;
`endif
                  end else if (body_q[0]) begin
                     read_q      <= 1'b1;
                     read_addr_q <= body_q[16:9];
                  end else begin
                     write_q      <= 1'b1;
                     write_addr_q <= body_q[16:9];
                     write_data_q <= body_q[8:1];
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rx_if.write      = write_q;
   assign rx_if.read       = read_q;
   assign rx_if.write_addr = write_addr_q;
   assign rx_if.write_data = write_data_q;
   assign rx_if.read_addr  = read_addr_q;
   assign rx_if.frame_err  = frame_err_q;
   assign rx_if.busy       = busy_q;
`ifdef PARITY_CHECK_EN
   assign rx_if.parity_err = parity_err_q;
`else
   assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_packet_rx.sv
`timescale 1ns/1ps
// Bench for uart_packet_rx: directed scenarios plus randomized packets against a packet-level model.
module tb_uart_packet_rx;
   localparam int CPB        = 16;
   localparam int SYNC       = 2;
   localparam int FRAME_CLKS = 20 * CPB;
   // posi start edge -> strobe: synchroniser, one IDLE detect cycle, half a bit, 19 bits to mid-stop
   localparam int LAT        = SYNC + 1 + CPB / 2 + 19 * CPB;
`ifdef PARITY_CHECK_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif
   localparam int K_WRITE = 0, K_READ = 1, K_FRAME = 2, K_PARITY = 3;

   typedef struct {
      int         kind;
      int         cyc;
      logic [7:0] addr;
      logic [7:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   logic posi;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   both_high = 0;
   ev_t  ev_q[$];
   logic [7:0] m_waddr, m_wdata, m_raddr;

   uart_packet_rx_if bus ();

   uart_packet_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk   (clk),
      .reset (reset),
      .posi  (posi),
      .rx_if (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every cycle an output pulse is high is logged, so a stretched pulse shows up as an extra event.
   always @(negedge clk) begin
      ev_t e;
      e.cyc = cyc;
      if (bus.write === 1'b1) begin
         e.kind = K_WRITE; e.addr = bus.write_addr; e.data = bus.write_data; ev_q.push_back(e);
      end
      if (bus.read === 1'b1) begin
         e.kind = K_READ; e.addr = bus.read_addr; e.data = 8'h00; ev_q.push_back(e);
      end
      if (bus.frame_err === 1'b1) begin
         e.kind = K_FRAME; e.addr = 8'h00; e.data = 8'h00; ev_q.push_back(e);
      end
      if (bus.parity_err === 1'b1) begin
         e.kind = K_PARITY; e.addr = 8'h00; e.data = 8'h00; ev_q.push_back(e);
      end
      if (bus.write === 1'b1 && bus.read === 1'b1) both_high++;
   end

   function automatic logic [17:0] make_pkt(input logic wrb, input logic [7:0] addr,
                                            input logic [7:0] data, input logic flip);
      logic [16:0] body;
      body = {addr, data, wrb};
      return {(^body) ^ flip, body};
   endfunction

   function automatic int predict(input logic [17:0] pkt, input logic stop);
      if (!stop) return K_FRAME;
      if (PARITY_EN && (^pkt)) return K_PARITY;
      return pkt[0] ? K_READ : K_WRITE;
   endfunction

   task automatic model_accept(input logic [17:0] pkt, input logic stop);
      case (predict(pkt, stop))
         K_WRITE: begin m_waddr = pkt[16:9]; m_wdata = pkt[8:1]; end
         K_READ:  m_raddr = pkt[16:9];
         default: ;
      endcase
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Caller is aligned 1 time unit after a rising edge; returns aligned the same way.
   task automatic send_frame(input logic [17:0] pkt, input logic stop, output int start_cyc);
      logic [19:0] fr;
      fr = {stop, pkt, 1'b0};
      start_cyc = cyc;
      for (int i = 0; i < 20; i++) begin
         posi = fr[i];
         idle(CPB);
      end
      posi = 1'b1;
   endtask

   task automatic test_reset();
      posi  = 1'b1;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      m_waddr = 8'h00; m_wdata = 8'h00; m_raddr = 8'h00;
      checks++;
      if ({bus.write, bus.read, bus.write_addr, bus.write_data, bus.read_addr,
           bus.frame_err, bus.parity_err, bus.busy} !== 30'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want 0", {bus.write, bus.read, bus.write_addr,
                  bus.write_data, bus.read_addr, bus.frame_err, bus.parity_err, bus.busy});
      end
      ev_q.delete();
   endtask

   task automatic test_write();
      logic [17:0] pkt; int s; ev_t e;
      pkt = make_pkt(1'b0, 8'h05, 8'hA5, 1'b0);
      model_accept(pkt, 1'b1);
      send_frame(pkt, 1'b1, s);
      checks++;
      if (ev_q.size() != 1) begin
         failures++; $display("FAIL write_events: got %0d want 1", ev_q.size()); ev_q.delete();
      end else begin
         e = ev_q.pop_front();
         checks++;
         if (e.kind !== K_WRITE) begin failures++; $display("FAIL write_kind: got %0d want %0d", e.kind, K_WRITE); end
         checks++;
         if ({e.addr, e.data} !== 16'h05A5) begin failures++; $display("FAIL write_payload: got %h want 05a5", {e.addr, e.data}); end
         checks++;
         if (e.cyc - s !== LAT) begin failures++; $display("FAIL write_latency: got %0d want %0d", e.cyc - s, LAT); end
      end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL write_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_read();
      logic [17:0] pkt; int s; ev_t e;
      pkt = make_pkt(1'b1, 8'h0F, 8'h00, 1'b0);
      model_accept(pkt, 1'b1);
      send_frame(pkt, 1'b1, s);
      checks++;
      if (ev_q.size() != 1) begin
         failures++; $display("FAIL read_events: got %0d want 1", ev_q.size()); ev_q.delete();
      end else begin
         e = ev_q.pop_front();
         checks++;
         if (e.kind !== K_READ || e.addr !== 8'h0F) begin
            failures++; $display("FAIL read_strobe: got kind %0d addr %h want kind %0d addr 0f", e.kind, e.addr, K_READ);
         end
      end
      checks++;
      if ({bus.write_addr, bus.write_data} !== 16'h05A5) begin
         failures++; $display("FAIL read_keeps_write_regs: got %h want 05a5", {bus.write_addr, bus.write_data});
      end
   endtask

   task automatic test_parity();
      logic [17:0] pkt; int s; ev_t e; int want;
      pkt = make_pkt(1'b0, 8'h05, 8'hA5, 1'b1);
      want = predict(pkt, 1'b1);
      model_accept(pkt, 1'b1);
      send_frame(pkt, 1'b1, s);
      checks++;
      if (ev_q.size() != 1) begin
         failures++; $display("FAIL parity_events: got %0d want 1", ev_q.size()); ev_q.delete();
      end else begin
         e = ev_q.pop_front();
         checks++;
         if (e.kind !== want) begin failures++; $display("FAIL parity_kind: got %0d want %0d", e.kind, want); end
      end
      checks++;
      if ({bus.write_addr, bus.write_data, bus.read_addr} !== {m_waddr, m_wdata, m_raddr}) begin
         failures++; $display("FAIL parity_regs: got %h want %h",
            {bus.write_addr, bus.write_data, bus.read_addr}, {m_waddr, m_wdata, m_raddr});
      end
   endtask

   task automatic test_frame_err();
      logic [17:0] pkt; int s; ev_t e;
      pkt = make_pkt(1'b0, 8'h5A, 8'hC3, 1'b0);
      send_frame(pkt, 1'b0, s);
      checks++;
      if (ev_q.size() != 1) begin
         failures++; $display("FAIL frame_events: got %0d want 1", ev_q.size()); ev_q.delete();
      end else begin
         e = ev_q.pop_front();
         checks++;
         if (e.kind !== K_FRAME) begin failures++; $display("FAIL frame_kind: got %0d want %0d", e.kind, K_FRAME); end
      end
      idle(24);
      checks++;
      if (bus.busy !== 1'b0 || ev_q.size() != 0) begin
         failures++; $display("FAIL frame_settle: got busy %b events %0d want 0 0", bus.busy, ev_q.size()); ev_q.delete();
      end
      checks++;
      if ({bus.write_addr, bus.write_data} !== {m_waddr, m_wdata}) begin
         failures++; $display("FAIL frame_regs: got %h want %h", {bus.write_addr, bus.write_data}, {m_waddr, m_wdata});
      end
      pkt = make_pkt(1'b0, 8'h01, 8'h3C, 1'b0);
      model_accept(pkt, 1'b1);
      send_frame(pkt, 1'b1, s);
      checks++;
      if (ev_q.size() != 1) begin
         failures++; $display("FAIL frame_next_events: got %0d want 1", ev_q.size()); ev_q.delete();
      end else begin
         e = ev_q.pop_front();
         checks++;
         if (e.kind !== K_WRITE || {e.addr, e.data} !== 16'h013C) begin
            failures++; $display("FAIL frame_next_write: got kind %0d payload %h want %0d 013c", e.kind, {e.addr, e.data}, K_WRITE);
         end
      end
   endtask

   task automatic test_false_start();
      posi = 1'b0;
      idle(4);
      posi = 1'b1;
      idle(2);
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL false_start_busy_high: got %b want 1", bus.busy); end
      idle(16);
      checks++;
      if (bus.busy !== 1'b0 || ev_q.size() != 0) begin
         failures++; $display("FAIL false_start_idle: got busy %b events %0d want 0 0", bus.busy, ev_q.size()); ev_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      logic [17:0] pkt; logic [19:0] fr; int s; ev_t e;
      pkt = make_pkt(1'b0, 8'h77, 8'h99, 1'b0);
      fr  = {1'b1, pkt, 1'b0};
      for (int i = 0; i < 10; i++) begin
         posi = fr[i];
         idle(CPB);
      end
      posi = fr[10];
      idle(CPB / 2);
      reset = 1'b1;
      posi  = 1'b1;
      idle(1);
      reset = 1'b0;
      m_waddr = 8'h00; m_wdata = 8'h00; m_raddr = 8'h00;
      checks++;
      if ({bus.write, bus.read, bus.write_addr, bus.write_data, bus.read_addr,
           bus.frame_err, bus.parity_err, bus.busy} !== 30'd0 || ev_q.size() != 0) begin
         failures++;
         $display("FAIL reset_mid_outputs: got %h events %0d want 0 0", {bus.write, bus.read, bus.write_addr,
                  bus.write_data, bus.read_addr, bus.frame_err, bus.parity_err, bus.busy}, ev_q.size());
         ev_q.delete();
      end
      idle(4);
      pkt = make_pkt(1'b0, 8'h02, 8'hFF, 1'b0);
      model_accept(pkt, 1'b1);
      send_frame(pkt, 1'b1, s);
      checks++;
      if (ev_q.size() != 1) begin
         failures++; $display("FAIL reset_next_events: got %0d want 1", ev_q.size()); ev_q.delete();
      end else begin
         e = ev_q.pop_front();
         checks++;
         if (e.kind !== K_WRITE || {e.addr, e.data} !== 16'h02FF) begin
            failures++; $display("FAIL reset_next_write: got kind %0d payload %h want %0d 02ff", e.kind, {e.addr, e.data}, K_WRITE);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [17:0] p0, p1; int s0, s1; ev_t e0, e1;
      p0 = make_pkt(1'b0, 8'($urandom), 8'($urandom), 1'b0);
      p1 = make_pkt(1'b1, 8'($urandom), 8'($urandom), 1'b0);
      model_accept(p0, 1'b1);
      model_accept(p1, 1'b1);
      send_frame(p0, 1'b1, s0);
      send_frame(p1, 1'b1, s1);
      checks++;
      if (ev_q.size() != 2) begin
         failures++; $display("FAIL b2b_events: got %0d want 2", ev_q.size()); ev_q.delete();
      end else begin
         e0 = ev_q.pop_front();
         e1 = ev_q.pop_front();
         checks++;
         if (e0.kind !== K_WRITE || {e0.addr, e0.data} !== {p0[16:9], p0[8:1]}) begin
            failures++; $display("FAIL b2b_first: got kind %0d payload %h want %0d %h", e0.kind, {e0.addr, e0.data}, K_WRITE, {p0[16:9], p0[8:1]});
         end
         checks++;
         if (e1.kind !== K_READ || e1.addr !== p1[16:9]) begin
            failures++; $display("FAIL b2b_second: got kind %0d addr %h want %0d %h", e1.kind, e1.addr, K_READ, p1[16:9]);
         end
         checks++;
         if (e1.cyc - e0.cyc !== FRAME_CLKS) begin
            failures++; $display("FAIL b2b_spacing: got %0d want %0d", e1.cyc - e0.cyc, FRAME_CLKS);
         end
      end
   endtask

   task automatic test_random();
      logic [17:0] pkt; logic stop; logic flip; int s; int want; ev_t e;
      for (int n = 0; n < 24; n++) begin
         flip = ($urandom_range(0, 3) == 0);
         stop = ($urandom_range(0, 4) != 0);
         pkt  = make_pkt(1'($urandom), 8'($urandom), 8'($urandom), flip);
         want = predict(pkt, stop);
         model_accept(pkt, stop);
         send_frame(pkt, stop, s);
         checks++;
         if (ev_q.size() != 1) begin
            failures++; $display("FAIL rand_events[%0d]: got %0d want 1", n, ev_q.size()); ev_q.delete();
         end else begin
            e = ev_q.pop_front();
            checks++;
            if (e.kind !== want) begin
               failures++; $display("FAIL rand_kind[%0d]: got %0d want %0d", n, e.kind, want);
            end else if (want == K_WRITE || want == K_READ) begin
               checks++;
               if (e.addr !== pkt[16:9] || (want == K_WRITE && e.data !== pkt[8:1])) begin
                  failures++; $display("FAIL rand_payload[%0d]: got %h want %h", n, {e.addr, e.data}, {pkt[16:9], pkt[8:1]});
               end
            end
         end
         checks++;
         if ({bus.write_addr, bus.write_data, bus.read_addr} !== {m_waddr, m_wdata, m_raddr}) begin
            failures++; $display("FAIL rand_regs[%0d]: got %h want %h", n,
               {bus.write_addr, bus.write_data, bus.read_addr}, {m_waddr, m_wdata, m_raddr});
         end
         // A low stop bit looks like a start edge, so let the resulting false start clear.
         if (!stop) idle(24 + $urandom_range(0, 8));
         else idle($urandom_range(0, 3));
      end
   endtask

   initial begin
      reset = 1'b1;
      posi  = 1'b1;
      idle(1);
      test_reset();
      test_write();
      test_read();
      test_parity();
      test_frame_err();
      test_false_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      idle(4);
      checks++;
      if (both_high !== 0) begin failures++; $display("FAIL write_read_overlap: got %0d want 0", both_high); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_packet_rx.md
Name: uart_packet_rx

Overview:
- Receive-side serial front end for the configuration register file.
- Deserialises 18-bit command packets arriving on `posi`, checks the frame and parity, and issues one-cycle write or read strobes with address and data.
- Sits directly upstream of the regfile write/read ports; the transmit path is handled elsewhere.

Parameters:
- CLKS_PER_BIT, 16, system clocks per serial bit; must be even and >= 4.
- SYNC_STAGES, 2, depth of the `posi` input synchroniser; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- posi  input  1  asynchronous serial input; idles high.
- write  output  1  one-cycle strobe: a valid write packet was received.
- read  output  1  one-cycle strobe: a valid read packet was received.
- write_addr  output  8  packet address; valid while `write` is high, held until the next accepted packet.
- write_data  output  8  packet data; valid while `write` is high, held until the next accepted packet.
- read_addr  output  8  packet address; valid while `read` is high, held until the next accepted packet.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch (only with PARITY_CHECK_EN).
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset state:
  - All outputs 0.
  - FSM in IDLE; bit and clock counters 0.
  - Synchroniser flops set to 1.
  - Reset takes priority over every other event, including mid-packet; the partial packet is discarded with no strobe and no error.
- Line format:
  - Start bit (0), then 18 packet bits LSB first, then one stop bit (1).
  - Packet bit 0 = wrb (0 = write, 1 = read).
  - Bits 8:1 = data; bits 16:9 = addr.
  - Bit 17 = even parity: XOR of bits 17:0 is 0.
- Synchroniser: `posi` passes through SYNC_STAGES flops. The FSM sees only the synchronised value, called `rx`. All timing below refers to `rx`.
- FSM states:
  - IDLE: on `rx` = 0, load clock counter and go to START.
  - START: count CLKS_PER_BIT/2 cycles to mid-bit, then sample.
    - `rx` = 1 is a false start: go to IDLE, no error.
    - `rx` = 0: reset counters and go to DATA.
  - DATA: sample `rx` every CLKS_PER_BIT cycles into a shift register, LSB first. After the 18th sample, go to STOP.
  - STOP: sample `rx` after CLKS_PER_BIT cycles, then go to IDLE in the next cycle.
- Stop-bit outcome:
  - `rx` = 0 at the stop sample: pulse frame_err; packet dropped.
  - `rx` = 1 and parity passes: packet accepted.
  - `rx` = 1 and parity fails: handled per PARITY_CHECK_EN.
- Output latency: strobe and address/data are registered in the cycle after the stop-bit sample. They are visible exactly 1 clk later, and the strobe is high for exactly 1 clk.
- Output registers:
  - Accepted write updates write_addr and write_data only.
  - Accepted read updates read_addr only.
  - `write` and `read` are never high in the same cycle.
  - Address and data registers are unchanged on dropped packets.
- Back-to-back packets: IDLE accepts a new start bit in the cycle after STOP, so a packet whose start edge immediately follows a full stop bit is received. No idle gap is needed beyond the stop bit.
- A `rx` = 0 seen while in IDLE in the same cycle a strobe is issued is a valid start.
- Counter width is $clog2(CLKS_PER_BIT). The bit counter is 5 bits and never wraps within a packet.
- No flow control: the downstream regfile accepts a strobe every cycle.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Bit 17 is checked.
  - On mismatch, the packet is dropped, parity_err pulses for 1 clk in the strobe cycle, and no write/read strobe is issued.
- Undefined:
  - Bit 17 is received and ignored.
  - parity_err is tied to 0.
  - Every frame with a valid stop bit is accepted.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2):
- Write packet, addr 0x05, data 0xA5, wrb 0, parity 0, with a good stop bit -> `write` pulses once, write_addr = 0x05, write_data = 0xA5. `read` stays 0. The pulse appears 1 clk after the mid-stop sample.
- Read packet, addr 0x0F, data 0x00, wrb 1, parity 1 -> `read` pulses once with read_addr = 0x0F. write_addr and write_data keep their prior values 0x05 and 0xA5.
- Write packet, addr 0x05, data 0xA5, with parity bit flipped to 1:
  - With PARITY_CHECK_EN: parity_err pulses, no write strobe, registers unchanged.
  - Without it: write strobe issued.
- Valid write packet with the stop bit driven 0 -> frame_err pulses, no strobe. A following valid packet, addr 0x01, data 0x3C, is then received correctly.
- `posi` low for 4 clks, then high -> FSM returns to IDLE after the mid-start sample. No strobe, no error, busy drops.
- Assert reset for 1 clk during data bit 9 of a write packet -> no strobe. All outputs are 0 the cycle after reset. A following packet, addr 0x02, data 0xFF, is received correctly.
- Two valid packets back to back with no idle gap -> two strobes spaced exactly 20*16 clks apart, both with correct data.
